// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - Shared types and op decode helpers for the iterative multiply/divide unit.
package mdu_iter_pkg;

  typedef logic [4:0] regName_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // funct3 bit that separates the divide group from the multiply group
  localparam int MDU_OP_IS_DIV = 2;

  function automatic logic op_is_div(input mdu_op_t f_op);
    return f_op[MDU_OP_IS_DIV];
  endfunction

  function automatic logic op_a_signed(input mdu_op_t f_op);
    return f_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input mdu_op_t f_op);
    return f_op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - Conditional two's-complement negate between magnitude and signed forms.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - Iterative RV32M multiply/divide unit; MDU_EARLY_OUT_EN enables 1-cycle special-case divides.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [4:0]            rd_in,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  input  logic                  flush,
  output logic                  ready,
  output logic                  valid_out,
  output logic [4:0]            rd_out,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;

  mdu_state_t           r_state;
  mdu_state_t           w_state_nxt;
  mdu_op_t              r_op;
  regName_t             r_rd;
  regName_t             r_rd_out;
  logic [W-1:0]         r_hi;
  logic [W-1:0]         r_lo;
  logic [W-1:0]         r_b;
  logic [W-1:0]         r_final;
  logic [W-1:0]         r_result;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_fin;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic                 r_bzero;

  mdu_op_t              w_op_in;
  logic                 w_accept;
  logic                 w_neg_a_in;
  logic                 w_neg_b_in;
  logic [W-1:0]         w_mag_a;
  logic [W-1:0]         w_mag_b;
  logic [W:0]           w_sum;
  logic [W:0]           w_diff;
  logic [2*W-1:0]       w_prod;
  logic [W-1:0]         w_quo_fix;
  logic [W-1:0]         w_quo;
  logic [W-1:0]         w_rem;
  logic [W-1:0]         w_final;

  assign w_op_in    = mdu_op_t'(op);
  assign w_accept   = (r_state == IDLE) && start && !flush;
  assign w_neg_a_in = op_a_signed(w_op_in) && opA[W-1];
  assign w_neg_b_in = op_b_signed(w_op_in) && opB[W-1];

  mdu_sign_fix #(.WIDTH(W)) u_fix_a (.i_val(opA), .i_neg(w_neg_a_in), .o_val(w_mag_a));
  mdu_sign_fix #(.WIDTH(W)) u_fix_b (.i_val(opB), .i_neg(w_neg_b_in), .o_val(w_mag_b));

  // r_lo holds the multiplier (mul) or the dividend being shifted out (div); r_b is multiplicand/divisor
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_diff = {r_hi, r_lo[W-1]} - {1'b0, r_b};

  mdu_sign_fix #(.WIDTH(2*W)) u_fix_prod (
    .i_val({r_hi, r_lo}), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_prod));
  mdu_sign_fix #(.WIDTH(W)) u_fix_quo (
    .i_val(r_lo), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_quo_fix));
  mdu_sign_fix #(.WIDTH(W)) u_fix_rem (
    .i_val(r_hi), .i_neg(r_neg_a), .o_val(w_rem));

  // A zero divisor leaves an all-ones magnitude; the sign fix must not touch it
  assign w_quo = r_bzero ? '1 : w_quo_fix;

  always_comb begin
    w_final = w_rem;
    case (r_op)
      OP_MUL:                       w_final = w_prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*W-1:W];
      OP_DIV, OP_DIVU:              w_final = w_quo;
      default:                      w_final = w_rem;
    endcase
  end

`ifdef MDU_EARLY_OUT_EN
  logic         w_bzero_in;
  logic         w_ovf_in;
  logic         w_early;
  logic [W-1:0] w_early_res;

  assign w_bzero_in = (opB == '0);
  assign w_ovf_in   = op_b_signed(w_op_in) && (opA == {1'b1, {(W-1){1'b0}}}) && (opB == '1);
  assign w_early    = op_is_div(w_op_in) && (w_bzero_in || w_ovf_in);

  always_comb begin
    w_early_res = '0;
    if (op[1]) w_early_res = w_bzero_in ? opA : '0;
    else       w_early_res = w_bzero_in ? '1 : opA;
  end
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          w_state_nxt = CALC;
`ifdef MDU_EARLY_OUT_EN
          if (w_early) w_state_nxt = DONE;
`endif
        end
      end
      CALC: begin
        if (flush)      w_state_nxt = IDLE;
        else if (r_fin) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_op     <= OP_MUL;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_final  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_op_in;
            r_rd    <= rd_in;
            r_neg_a <= w_neg_a_in;
            r_neg_b <= w_neg_b_in;
            r_bzero <= (opB == '0);
            r_hi    <= '0;
            r_lo    <= w_mag_a;
            r_b     <= w_mag_b;
            r_cnt   <= '0;
            r_fin   <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
            if (w_early) r_final <= w_early_res;
`endif
          end
        end
        CALC: begin
          if (!flush) begin
            if (!r_fin) begin
              if (op_is_div(r_op)) begin
                if (!w_diff[W]) begin
                  r_hi <= w_diff[W-1:0];
                  r_lo <= {r_lo[W-2:0], 1'b1};
                end else begin
                  r_hi <= {r_hi[W-2:0], r_lo[W-1]};
                  r_lo <= {r_lo[W-2:0], 1'b0};
                end
              end else begin
                r_hi <= w_sum[W:1];
                r_lo <= {w_sum[0], r_lo[W-1:1]};
              end
              if (r_cnt == CNT_WIDTH'(W - 1)) r_fin <= 1'b1;
              else                            r_cnt <= r_cnt + 1'b1;
            end else begin
              r_final <= w_final;
            end
          end
        end
        DONE: begin
          if (!flush) begin
            r_result <= r_final;
            r_rd_out <= r_rd;
          end
        end
        default: ;
      endcase
    end
  end

  // The visible result only moves on an unflushed DONE, so a flush leaves the previous value in place
  assign ready     = (r_state == IDLE);
  assign valid_out = (r_state == DONE) && !flush;
  assign result    = valid_out ? r_final : r_result;
  assign rd_out    = valid_out ? r_rd : r_rd_out;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - Self-checking bench for mdu_iter: vector table, random ops vs model, flush and reset corners.
module tb_mdu_iter;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  rd_in;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        ready;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic [31:0] result;

  mdu_iter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rstN(rstN), .start(start), .op(op), .rd_in(rd_in),
    .opA(opA), .opB(opB), .flush(flush), .ready(ready),
    .valid_out(valid_out), .rd_out(rd_out), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  // lat = k where valid_out is high in the cycle after edge E+k (E = accept edge)
  localparam int NORMAL_LAT = 33;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  vec_t        vecs[16];
  exp_t        sb[$];
  int          total;
  int          bad;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb_v, ub;
    logic [31:0] r;
    logic        ovf;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = '0;
    r    = '0;
    case (f_op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0];  end
      3'd1: begin p = sa * sb_v;               r = p[63:32]; end
      3'd2: begin p = sa * ub;                 r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input bit special);
    exp_t e;
    int   k;
    bit   seen;
    e.res = exp_res;
    e.rd  = rd;
    e.lat = (EARLY && special) ? 0 : NORMAL_LAT;
    sb.push_back(e);
    @(negedge clk);
    op = f_op; opA = a; opB = b; rd_in = rd; start = 1'b1;
    check("ready_before_start", {63'b0, ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 80) begin
      if (valid_out) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("valid_seen", {63'b0, seen}, 64'd1);
    e = sb.pop_front();
    if (seen) begin
      check("result", {32'b0, result}, {32'b0, e.res});
      check("rd_out", {59'b0, rd_out}, {59'b0, e.rd});
      check("latency", 64'(k), 64'(e.lat));
      last_res = e.res;
      last_rd  = e.rd;
      @(negedge clk);
      check("valid_one_cycle", {63'b0, valid_out}, 64'd0);
      check("ready_after_done", {63'b0, ready}, 64'd1);
      check("result_hold", {32'b0, result}, {32'b0, e.res});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    bit          sp;
    int          vcount;

    total = 0; bad = 0;
    last_res = '0; last_rd = '0;
    rstN = 1'b0; start = 1'b0; flush = 1'b0;
    op = '0; rd_in = '0; opA = '0; opB = '0;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0};
    vecs[3]  = '{3'd2, 32'h8000_0000,  32'h8000_0000, 5'd3,  32'hC000_0000, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h7FFF_FFFC, 1'b0};
    vecs[7]  = '{3'd4, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{3'd6, 32'd5,          32'd0,         5'd9,  32'd5,         1'b1};
    vecs[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1};
    vecs[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'd0,         1'b1};
    vecs[11] = '{3'd5, 32'd5,          32'd0,         5'd12, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{3'd7, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'd1,         1'b0};
    vecs[13] = '{3'd0, 32'h0001_0000,  32'h0001_0000, 5'd0,  32'd0,         1'b0};
    vecs[14] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1};
    vecs[15] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, 1'b0};

    @(negedge clk);
    check("reset_ready", {63'b0, ready}, 64'd1);
    check("reset_valid", {63'b0, valid_out}, 64'd0);
    check("reset_result", {32'b0, result}, 64'd0);
    check("reset_rd_out", {59'b0, rd_out}, 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].special);

    for (int i = 0; i < 8; i++) begin
      r_op = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = (i % 4 == 3) ? 32'd0 : $urandom;
      rrd  = 5'($urandom_range(0, 31));
      sp   = r_op[2] && ((rb == 0) || ((r_op == 3'd4 || r_op == 3'd6) &&
             ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
      run_op(r_op, ra, rb, rrd, model(r_op, ra, rb), sp);
    end

    // flush during CALC: op abandoned, old result kept, unit idle next cycle
    @(negedge clk);
    op = 3'd0; opA = 32'd5; opB = 32'd6; rd_in = 5'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    check("flush_calc_valid", {63'b0, valid_out}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc_ready", {63'b0, ready}, 64'd1);
    check("flush_calc_result", {32'b0, result}, {32'b0, last_res});
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_out) vcount++;
    end
    check("flush_calc_no_valid", 64'(vcount), 64'd0);
    run_op(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 1'b0);

    // flush in IDLE wins over start
    @(negedge clk);
    op = 3'd0; opA = 32'd9; opB = 32'd9; rd_in = 5'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_not_accepted", {63'b0, ready}, 64'd1);

    // flush in DONE: strobe suppressed, visible result unchanged
    @(negedge clk);
    op = 3'd0; opA = 32'd2; opB = 32'd3; rd_in = 5'd21; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (NORMAL_LAT) @(negedge clk);
    check("done_reached", {63'b0, valid_out}, 64'd1);
    flush = 1'b1;
    #1;
    check("flush_done_valid", {63'b0, valid_out}, 64'd0);
    check("flush_done_result", {32'b0, result}, {32'b0, last_res});
    check("flush_done_rd", {59'b0, rd_out}, {59'b0, last_rd});
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_ready", {63'b0, ready}, 64'd1);
    check("flush_done_result_kept", {32'b0, result}, {32'b0, last_res});

    // asynchronous reset between edges mid-CALC
    @(negedge clk);
    op = 3'd5; opA = 32'd100; opB = 32'd7; rd_in = 5'd19; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    check("areset_ready", {63'b0, ready}, 64'd1);
    check("areset_valid", {63'b0, valid_out}, 64'd0);
    check("areset_result", {32'b0, result}, 64'd0);
    check("areset_rd_out", {59'b0, rd_out}, 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    last_res = '0;
    last_rd  = '0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_out) vcount++;
    end
    check("areset_no_valid", 64'(vcount), 64'd0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd25, 32'hFFFF_FFFD, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands (rs1/rs2 data) plus the destination register.
- Returns a result, rd and a one-cycle write strobe that drive the register-file write port (data_in/rd/wen) through writeback.
- Frees the single-cycle ALU from multi-cycle M-extension ops.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstN  input  1  asynchronous active-low reset.
- start  input  1  request; accepted when start && ready.
- op  input  3  mdu_op_t (funct3 encoding, see Behaviour).
- rd_in  input  5  regName_t destination.
- opA  input  DATA_WIDTH  rs1 value (register-file regA_out).
- opB  input  DATA_WIDTH  rs2 value (register-file regB_out).
- flush  input  1  kill any in-flight op (pipeline flush).
- ready  output  1  unit idle and able to accept.
- valid_out  output  1  one-cycle result strobe; writeback drives wen from it.
- rd_out  output  5  destination for the result.
- result  output  DATA_WIDTH  final result.

Behaviour:
- Reset (asynchronous, rstN=0): state=IDLE, ready=1, valid_out=0, result=0, rd_out=0, counter=0, internal accumulators=0. Reset mid-operation abandons the op; no valid_out is produced for it.
- op encoding: 000 MUL (low half), 001 MULH (signed x signed, high half), 010 MULHSU (signed rs1 x unsigned rs2, high half), 011 MULHU (unsigned, high half), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE: ready=1. On start && !flush, latch opA, opB, op and rd_in, load the accumulators, set counter=0, and go to CALC.
  - CALC: ready=0. One iteration per cycle. After the iteration with counter==DATA_WIDTH-1, go to DONE.
  - DONE: valid_out=1 for exactly one cycle, with result and rd_out valid. Go to IDLE.
- result and rd_out hold their last values until the next DONE.
- Latency: the accept edge is E. valid_out is high in the cycle after edge E+DATA_WIDTH+1 (33 cycles for 32-bit). ready returns on the following cycle.
- Back-to-back: start is ignored while ready=0; no queueing.
- Multiply:
  - Operate on magnitudes (signed operands negated when their MSB is set and the op treats them as signed).
  - Unsigned shift-add into a 2*DATA_WIDTH product, one multiplier bit per cycle.
  - Negate the product in the transition to DONE when the operand signs differ.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring, one quotient bit per cycle on magnitudes. Final sign fix: quotient negative iff signs differ; remainder takes the sign of the dividend.
- Divide by zero (opB==0): quotient=all ones; remainder=opA. Applies to both signed and unsigned.
- Signed overflow (opA=most-negative, opB=-1, DIV/REM): quotient=opA, remainder=0.
- rd_in==0: executes normally, rd_out=0. The register file discards the write.
- flush:
  - In CALC or DONE: next state IDLE, valid_out forced 0 that cycle, result unchanged.
  - In IDLE: start is ignored (flush wins over start).

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: in IDLE, an accepted divide-by-zero or signed-overflow op goes straight to DONE with the special-case result. Latency is 1 cycle (valid_out in the cycle after the accept edge).
- Not defined: these cases run the full DATA_WIDTH iterations and produce the same values with normal latency.
- The result values are identical with or without the macro.

Decomposition:
- Package definitions gains:
  - typedef enum logic [2:0] mdu_op_t (values as above).
  - typedef enum logic [1:0] mdu_state_t {IDLE, CALC, DONE}.
  - localparam MDU_OP_IS_DIV = op[2].
- regName_t is reused for rd_in and rd_out.
- One natural sub-module: mdu_sign_fix, purely combinational. It takes magnitudes and sign flags and produces signed results (negate/select). It is used at operand load and at the CALC to DONE transition.

Test Plan:
- MUL: opA=7, opB=-3 (0xFFFFFFFD) -> result=0xFFFFFFEB, valid_out 33 cycles after accept, rd_out=rd_in.
- MULH/MULHU/MULHSU with opA=opB=0x80000000 -> MULH 0x40000000, MULHU 0x40000000, MULHSU 0xC0000000.
- DIV/REM: opA=-7, opB=2 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Special cases:
  - DIV by 0 with opA=5 -> 0xFFFFFFFF; REM by 0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - Latency is 1 cycle with MDU_EARLY_OUT_EN and 33 cycles without.
- flush asserted at CALC cycle 10 -> no valid_out, ready=1 next cycle, and a fresh MUL 3x4 then yields 12.
- rstN pulsed low mid-CALC (asynchronously, between edges) -> outputs immediately return to reset values, no valid_out, and a subsequent op completes correctly.
